// File: rtl/snn_pkg.sv
// Shared types for the rank-order image path: transmitter FSM states and
// the index-width helper that the sorter and the transmitter both use.
package snn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // Width of a pixel index for an image of image_size pixels.
  function automatic int index_width(input int image_size);
    return $clog2(image_size) + 1;
  endfunction

endpackage

// File: rtl/rank_spike_tx.sv
// Captures the rank-ordered pixel list on done and streams the first N_SPIKES
// indexes as AER spikes over valid/ready, brightest pixel first.
module rank_spike_tx
  import snn_pkg::*;
#(
  parameter int IMAGE_SIZE      = 5,
  parameter int IMAGE_SIZE_BITS = index_width(IMAGE_SIZE) - 1,
  parameter int N_SPIKES        = IMAGE_SIZE
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic [IMAGE_SIZE-1:0][IMAGE_SIZE_BITS:0] sorted_indexes,
  input  logic                                   done,
  output logic [IMAGE_SIZE_BITS:0]               aer_addr,
  output logic                                   aer_valid,
  input  logic                                   aer_ready,
  output logic                                   aer_last,
  output logic                                   busy,
  output logic                                   frame_done,
  output logic                                   overrun
);

  localparam int IW = IMAGE_SIZE_BITS + 1;
  localparam logic [IMAGE_SIZE_BITS:0] LAST_RANK = IW'(N_SPIKES - 1);

  tx_state_t                state_reg, state_next;
  logic [IMAGE_SIZE_BITS:0] rank_reg, rank_next;
  logic [IMAGE_SIZE_BITS:0] cap_buf_reg [N_SPIKES];
  logic                     frame_done_reg, frame_done_next;
  logic                     overrun_reg, overrun_next;
  logic                     load;
  logic                     at_last;
  logic [IMAGE_SIZE_BITS:0] addr_sel;

  assign at_last = (rank_reg == LAST_RANK);

  always_comb begin
    state_next      = state_reg;
    rank_next       = rank_reg;
    load            = 1'b0;
    frame_done_next = 1'b0;
    overrun_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (done) begin
          state_next = SEND;
          rank_next  = '0;
          load       = 1'b1;
        end
      end
      SEND: begin
        // A new list arriving mid-frame is dropped; only flag it.
        if (done) begin
          overrun_next = 1'b1;
        end
        if (aer_ready) begin
          if (at_last) begin
            state_next      = IDLE;
            frame_done_next = 1'b1;
          end else begin
            rank_next = rank_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= IDLE;
      rank_reg       <= '0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rank_reg       <= rank_next;
      frame_done_reg <= frame_done_next;
      overrun_reg    <= overrun_next;
    end
  end

  for (genvar gi = 0; gi < N_SPIKES; gi++) begin : g_buf
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cap_buf_reg[gi] <= '0;
      end else if (load) begin
        cap_buf_reg[gi] <= sorted_indexes[gi];
      end
    end
  end

  // Compare-based select keeps the rank width independent of N_SPIKES.
  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < N_SPIKES; i++) begin
      if (rank_reg == IW'(i)) begin
        addr_sel = cap_buf_reg[i];
      end
    end
  end

  assign aer_valid  = (state_reg == SEND);
  assign aer_addr   = aer_valid ? addr_sel : '0;
  assign aer_last   = aer_valid && at_last;
  assign busy       = aer_valid;
  assign frame_done = frame_done_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_rank_spike_tx.sv
// Directed bench for rank_spike_tx: full-length instance driven from a vector
// table, plus a 2-spike instance and an asynchronous mid-frame reset sequence.
module tb_rank_spike_tx;

  typedef logic [4:0][3:0] list_t;

  typedef struct {
    logic       done;
    list_t      list;
    logic       ready;
    logic       e_valid;
    logic [3:0] e_addr;
    logic       e_last;
    logic       e_busy;
    logic       e_fd;
    logic       e_ov;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;

  list_t      sorted5, sorted2;
  logic       done5 = 1'b0, done2 = 1'b0;
  logic       ready5 = 1'b0, ready2 = 1'b0;
  logic [3:0] addr5, addr2;
  logic       valid5, last5, busy5, fd5, ov5;
  logic       valid2, last2, busy2, fd2, ov2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  rank_spike_tx #(.IMAGE_SIZE(5), .N_SPIKES(5)) dut5 (
    .CLK(CLK), .RST(RST), .sorted_indexes(sorted5), .done(done5),
    .aer_addr(addr5), .aer_valid(valid5), .aer_ready(ready5), .aer_last(last5),
    .busy(busy5), .frame_done(fd5), .overrun(ov5)
  );

  rank_spike_tx #(.IMAGE_SIZE(5), .N_SPIKES(2)) dut2 (
    .CLK(CLK), .RST(RST), .sorted_indexes(sorted2), .done(done2),
    .aer_addr(addr2), .aer_valid(valid2), .aer_ready(ready2), .aer_last(last2),
    .busy(busy2), .frame_done(fd2), .overrun(ov2)
  );

  function automatic list_t mk(input int a0, input int a1, input int a2,
                               input int a3, input int a4);
    list_t l;
    l[0] = 4'(a0); l[1] = 4'(a1); l[2] = 4'(a2); l[3] = 4'(a3); l[4] = 4'(a4);
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check5(input string tag, input logic v, input logic [3:0] a,
                        input logic l, input logic b, input logic f, input logic o);
    check({tag, ".valid"}, 32'(valid5), 32'(v));
    check({tag, ".addr"},  32'(addr5),  32'(a));
    check({tag, ".last"},  32'(last5),  32'(l));
    check({tag, ".busy"},  32'(busy5),  32'(b));
    check({tag, ".fd"},    32'(fd5),    32'(f));
    check({tag, ".ov"},    32'(ov5),    32'(o));
  endtask

  task automatic check2(input string tag, input logic v, input logic [3:0] a,
                        input logic l, input logic b, input logic f, input logic o);
    check({tag, ".valid"}, 32'(valid2), 32'(v));
    check({tag, ".addr"},  32'(addr2),  32'(a));
    check({tag, ".last"},  32'(last2),  32'(l));
    check({tag, ".busy"},  32'(busy2),  32'(b));
    check({tag, ".fd"},    32'(fd2),    32'(f));
    check({tag, ".ov"},    32'(ov2),    32'(o));
  endtask

  vec_t vecs[$];

  task automatic add(input logic d, input list_t l, input logic r, input logic v,
                     input int a, input logic la, input logic b, input logic f,
                     input logic o);
    vec_t x;
    x.done = d; x.list = l; x.ready = r; x.e_valid = v; x.e_addr = 4'(a);
    x.e_last = la; x.e_busy = b; x.e_fd = f; x.e_ov = o;
    vecs.push_back(x);
  endtask

  initial begin
    list_t la, lz, lc, ln;
    la = mk(3, 0, 4, 1, 2);
    lz = mk(0, 0, 0, 0, 0);
    lc = mk(1, 2, 3, 4, 0);
    ln = mk(7, 7, 7, 7, 7);
    //   done list ready | valid addr last busy fd ov   (expected in this cycle)
    // Basic frame, done in c0.
    add(1, la, 1,  0, 0, 0, 0, 0, 0);
    add(0, lz, 1,  1, 3, 0, 1, 0, 0);
    add(0, lz, 1,  1, 0, 0, 1, 0, 0);
    add(0, lz, 1,  1, 4, 0, 1, 0, 0);
    add(0, lz, 1,  1, 1, 0, 1, 0, 0);
    add(0, lz, 1,  1, 2, 1, 1, 0, 0);
    // frame_done cycle accepts a new done; then backpressure frame.
    add(1, la, 1,  0, 0, 0, 0, 1, 0);
    add(0, lz, 1,  1, 3, 0, 1, 0, 0);
    add(0, lz, 0,  1, 0, 0, 1, 0, 0);
    add(0, lz, 0,  1, 0, 0, 1, 0, 0);
    add(0, lz, 0,  1, 0, 0, 1, 0, 0);
    add(0, lz, 1,  1, 0, 0, 1, 0, 0);
    add(0, lz, 1,  1, 4, 0, 1, 0, 0);
    add(0, lz, 1,  1, 1, 0, 1, 0, 0);
    add(0, lz, 1,  1, 2, 1, 1, 0, 0);
    add(0, lz, 1,  0, 0, 0, 0, 1, 0);
    add(0, lz, 1,  0, 0, 0, 0, 0, 0);
    // Overrun at t+3 and again on the last-transfer cycle.
    add(1, lc, 1,  0, 0, 0, 0, 0, 0);
    add(0, lz, 1,  1, 1, 0, 1, 0, 0);
    add(0, lz, 1,  1, 2, 0, 1, 0, 0);
    add(1, ln, 1,  1, 3, 0, 1, 0, 0);
    add(0, lz, 1,  1, 4, 0, 1, 0, 1);
    add(1, ln, 1,  1, 0, 1, 1, 0, 0);
    add(0, lz, 1,  0, 0, 0, 0, 1, 1);
    add(0, lz, 1,  0, 0, 0, 0, 0, 0);

    sorted5 = lz;
    sorted2 = lz;
    repeat (2) @(negedge CLK);
    check5("reset", 0, 0, 0, 0, 0, 0);
    check2("reset2", 0, 0, 0, 0, 0, 0);
    RST = 1'b0;

    foreach (vecs[i]) begin
      @(negedge CLK);
      check5($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_addr, vecs[i].e_last,
             vecs[i].e_busy, vecs[i].e_fd, vecs[i].e_ov);
      done5   = vecs[i].done;
      sorted5 = vecs[i].list;
      ready5  = vecs[i].ready;
    end

    // Asynchronous reset in the middle of a frame.
    @(negedge CLK);
    done5 = 1'b1; sorted5 = mk(2, 3, 1, 0, 4); ready5 = 1'b1;
    @(negedge CLK);
    done5 = 1'b0;
    check5("rst.t1", 1, 2, 0, 1, 0, 0);
    @(negedge CLK);
    check5("rst.t2", 1, 3, 0, 1, 0, 0);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 check5("rst.async", 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check5("rst.idle", 0, 0, 0, 0, 0, 0);
    done5 = 1'b1; sorted5 = mk(4, 1, 0, 2, 3);
    @(negedge CLK);
    done5 = 1'b0;
    check5("rst.new0", 1, 4, 0, 1, 0, 0);
    @(negedge CLK);
    check5("rst.new1", 1, 1, 0, 1, 0, 0);

    // Truncated frame on the 2-spike instance.
    done2 = 1'b1; sorted2 = mk(4, 2, 0, 1, 3); ready2 = 1'b1;
    @(negedge CLK);
    done2 = 1'b0;
    check2("trunc.r0", 1, 4, 0, 1, 0, 0);
    @(negedge CLK);
    check2("trunc.r1", 1, 2, 1, 1, 0, 0);
    @(negedge CLK);
    check2("trunc.fd", 0, 0, 0, 0, 1, 0);
    @(negedge CLK);
    check2("trunc.idle", 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rank_spike_tx.md
# rank_spike_tx

- Transmitter at the downstream end of the rank-order sorter interface.
- Captures the sorted pixel-index list when the sorter pulses `done`, then streams the first N_SPIKES indexes as address-event (AER) spikes over a valid/ready handshake, brightest pixel first.
- Sits between the image sorter and the SNN core's input-spike port.

## Interface
Parameters:
- IMAGE_SIZE, 5, number of pixels / entries in the sorted list
- IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), index width minus one
- N_SPIKES, IMAGE_SIZE, spikes emitted per frame; legal range 1..IMAGE_SIZE

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- sorted_indexes  in  [IMAGE_SIZE_BITS:0] x IMAGE_SIZE  rank-ordered pixel indexes; entry 0 is the brightest pixel
- done  in  1  one-cycle pulse; sorted_indexes valid in this cycle only
- aer_addr  out  [IMAGE_SIZE_BITS:0]  pixel address of the current spike
- aer_valid  out  1  spike present
- aer_ready  in  1  core accepts the spike
- aer_last  out  1  marks the final spike of the frame; qualified by aer_valid
- busy  out  1  frame captured and not yet fully sent
- frame_done  out  1  one-cycle pulse after the last spike transfers
- overrun  out  1  one-cycle pulse when done arrives while busy

## Operation
- States: IDLE, SEND.
- Internal registers:
  - capture buffer buf[0:N_SPIKES-1], holding only the first N_SPIKES entries;
  - rank counter of width IMAGE_SIZE_BITS+1.
- IDLE:
  - if done=1, copy sorted_indexes[0..N_SPIKES-1] into buf, clear rank to 0, go to SEND;
  - otherwise stay in IDLE.
- SEND:
  - aer_valid=1, aer_addr=buf[rank], aer_last=(rank==N_SPIKES-1);
  - transfer occurs when aer_valid && aer_ready;
  - on a transfer with rank<N_SPIKES-1, rank increments;
  - on a transfer with rank==N_SPIKES-1, go to IDLE;
  - without a transfer, aer_addr and aer_last hold stable and aer_valid stays high; no retraction.
- busy=1 exactly when state==SEND.
- done while in SEND:
  - pulse overrun for one cycle;
  - the new list is discarded;
  - the current frame continues unaffected.
- Index values are transmitted unmodified; the block does no range checking.
- Reset values:
  - state IDLE, rank 0, buf all 0;
  - aer_valid 0, aer_addr 0, aer_last 0;
  - busy 0, frame_done 0, overrun 0.
- Reset mid-frame: the pending frame is lost and the block returns to IDLE. No partial resume.

## Timing
- Capture: done high in cycle t, so aer_valid is high from cycle t+1 with aer_addr=buf[0].
- Throughput: one spike per cycle with aer_ready held high; no bubbles between ranks.
- Frame latency with no backpressure: the last transfer is in cycle t+N_SPIKES.
- frame_done is registered: it pulses in the cycle after the last transfer, while already in IDLE.
- A done arriving in that same cycle (frame_done high) is accepted normally; overrun stays 0.
- A done in the cycle of the last transfer, while still in SEND, counts as an overrun.
- All outputs are registered or decoded from registered state. aer_ready has no combinational path to any output other than through the next-state logic.

## Structure
- Shared package snn_pkg holds the tx_state_t enum {IDLE, SEND}.
- Index-width constant: IMAGE_SIZE_BITS+1, derived in the package function or parameter, shared with the sorter.
- No sub-module; buffer, counter and FSM live in one module.

## Test plan
- Basic frame: IMAGE_SIZE=5, N_SPIKES=5, aer_ready=1, sorted_indexes={3,0,4,1,2}, done at t.
  - aer_addr is 3,0,4,1,2 in cycles t+1..t+5;
  - aer_last only at t+5;
  - frame_done at t+6;
  - busy high t+1..t+5.
- Backpressure: same list, aer_ready low in cycles t+2..t+4.
  - aer_addr holds 0 with aer_valid=1 through the stall;
  - sequence completes with the last transfer at t+8 and frame_done at t+9.
- Truncation: N_SPIKES=2, list {4,2,0,1,3}.
  - emits 4, then 2 with aer_last;
  - frame_done two cycles after capture+1.
- Overrun and back-to-back:
  - done again at t+3 → overrun pulse at t+4, original stream unchanged;
  - done at the frame_done cycle → new frame starts the next cycle, overrun=0.
- Reset mid-frame: RST asserted at t+3 (async).
  - all outputs 0 immediately;
  - after release, block in IDLE;
  - a subsequent done starts a fresh frame at rank 0.
